// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: walks NUM_BLOCKS 16-bit SECDED codewords in a shared byte
// memory, decodes each one and writes back {flags, 3'b000, data[10:0]}.
// Optional build macro ECC_SCRUB_STATS_EN enables the single/double error
// counters; without it sgl_cnt/dbl_cnt are tied to zero.
module ecc_scrub_ctrl #(
    parameter int NUM_BLOCKS = 15,
    parameter int SRC_BASE   = 30,
    parameter int DST_BASE   = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Busy,
    output logic       Done,
    output logic       mem_req,
    input  logic       mem_gnt,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [3:0] sgl_cnt,
    output logic [3:0] dbl_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_LO  = 3'd1;
    localparam logic [2:0] RD_HI  = 3'd2;
    localparam logic [2:0] DECODE = 3'd3;
    localparam logic [2:0] WR_LO  = 3'd4;
    localparam logic [2:0] WR_HI  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
    localparam logic [7:0] DST_B    = 8'(DST_BASE);
    localparam logic [7:0] LAST_IDX = 8'(NUM_BLOCKS - 1);

    logic [2:0]  state;
    logic [7:0]  idx;
    logic        lo_pend;
    logic        done_q;
    logic [7:0]  lo_byte;
    logic [15:0] result;
    logic [15:0] dec_word;
    logic [7:0]  src_lo;
    logic [7:0]  dst_lo;

    // Hamming(15,11) plus overall parity. Syndrome bits come from the usual
    // position masks; a set overall parity means a single flip at position
    // syn (syn==0 is p0 itself), otherwise a non-zero syndrome is a double.
    function automatic logic [15:0] ecc_decode(input logic [15:0] cw);
        logic [3:0]  syn;
        logic        par;
        logic [15:0] fixed;
        logic [1:0]  flags;
        syn[0] = ^(cw & 16'hAAAA);
        syn[1] = ^(cw & 16'hCCCC);
        syn[2] = ^(cw & 16'hF0F0);
        syn[3] = ^(cw & 16'hFF00);
        par    = ^cw;
        fixed  = cw;
        flags  = 2'b00;
        if (par) begin
            fixed = cw ^ (16'd1 << syn);
            flags = 2'b01;
        end else if (syn != 4'd0) begin
            flags = 2'b10;
        end
        return {flags, 3'b000, fixed[15:9], fixed[7:5], fixed[3]};
    endfunction

    assign dec_word = ecc_decode({mem_rdata, lo_byte});
    assign src_lo   = SRC_B + (idx << 1);
    assign dst_lo   = DST_B + (idx << 1);

    // Control FSM: block sequencing, read-data-valid tracking, done pulse
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            idx     <= 8'd0;
            lo_pend <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            lo_pend <= (state == RD_LO) && mem_gnt;
            done_q  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= RD_LO;
                        idx   <= 8'd0;
                    end
                end
                RD_LO:  if (mem_gnt) state <= RD_HI;
                RD_HI:  if (mem_gnt) state <= DECODE;
                DECODE: state <= WR_LO;
                WR_LO:  if (mem_gnt) state <= WR_HI;
                WR_HI: begin
                    if (mem_gnt) begin
                        if (idx < LAST_IDX) begin
                            idx   <= idx + 8'd1;
                            state <= RD_LO;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath capture: low byte on the first RD_HI cycle, result in DECODE
    always_ff @(posedge Clk) begin
        if ((state == RD_HI) && lo_pend) lo_byte <= mem_rdata;
        if (state == DECODE)             result  <= dec_word;
    end

`ifdef ECC_SCRUB_STATS_EN
    // Saturating error statistics, cleared when a run is accepted
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sgl_cnt <= 4'd0;
            dbl_cnt <= 4'd0;
        end else if ((state == IDLE) && Start) begin
            sgl_cnt <= 4'd0;
            dbl_cnt <= 4'd0;
        end else if (state == DECODE) begin
            if ((dec_word[15:14] == 2'b01) && (sgl_cnt != 4'd15)) sgl_cnt <= sgl_cnt + 4'd1;
            if ((dec_word[15:14] == 2'b10) && (dbl_cnt != 4'd15)) dbl_cnt <= dbl_cnt + 4'd1;
        end
    end
`else
    assign sgl_cnt = 4'd0;
    assign dbl_cnt = 4'd0;
`endif

    // Memory port and status outputs decoded from the current state
    always_comb begin
        Busy      = (state != IDLE) && (state != DONE);
        Done      = done_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        case (state)
            RD_LO: begin
                mem_req  = 1'b1;
                mem_addr = src_lo;
            end
            RD_HI: begin
                mem_req  = 1'b1;
                mem_addr = src_lo + 8'd1;
            end
            WR_LO: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_lo;
                mem_wdata = result[7:0];
            end
            WR_HI: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_lo + 8'd1;
                mem_wdata = result[15:8];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: byte memory with a randomly
// stalling grant, a bit-position decode model, per-cycle access checking.
module tb_ecc_scrub_ctrl;

    localparam int N   = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic       mem_req;
    logic       mem_gnt;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [3:0] sgl_cnt;
    logic [3:0] dbl_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    logic [15:0] src_cw [0:N-1];
    bit          gnt_rand = 1'b0;
    int          acc_n = 0;
    int          done_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_addr;
    logic [7:0]  prev_wdata;
    logic        prev_we;
    int          blk;
    int          ph;
    logic [15:0] exp_word;

    ecc_scrub_ctrl #(.NUM_BLOCKS(N), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Busy(Busy), .Done(Done),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: walk bit positions, fix the syndrome position on
    // odd overall parity, then gather data from non-power-of-two positions.
    function automatic logic [15:0] model(input logic [15:0] cw);
        int          s = 0;
        int          q = 0;
        int          d = 0;
        logic [15:0] c = cw;
        logic [10:0] data = '0;
        logic [1:0]  fl;
        for (int i = 0; i < 16; i++) begin
            if (c[i]) begin
                q = q ^ 1;
                s = s ^ i;
            end
        end
        if (q != 0) c[s] = ~c[s];
        for (int i = 3; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                data[d] = c[i];
                d++;
            end
        end
        fl = (q != 0) ? 2'b01 : ((s != 0) ? 2'b10 : 2'b00);
        return {fl, 3'b000, data};
    endfunction

    // Memory behind the arbitrated port; read data appears the next cycle
    always @(posedge Clk) begin
        if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Grant driver
    always @(posedge Clk) begin
        #1;
        mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Per-cycle protocol and access-sequence checking
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            chk("req_without_busy", 32'(mem_req & ~Busy), 0);
            chk("done_with_busy", 32'(Done & Busy), 0);
            if (prev_stall && mem_req) begin
                chk("stall_addr", mem_addr, prev_addr);
                chk("stall_we", mem_we, prev_we);
                chk("stall_wdata", mem_wdata, prev_wdata);
            end
            prev_stall = mem_req && !mem_gnt;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (Done) done_cnt++;
            if (mem_req && mem_gnt) begin
                chk("access_in_range", 32'(acc_n < 4 * N), 1);
                if (acc_n < 4 * N) begin
                    blk = acc_n / 4;
                    ph  = acc_n % 4;
                    exp_word = model(src_cw[blk]);
                    if (ph < 2) chk("access_addr", mem_addr, 32'(SRC + 2 * blk + ph));
                    else        chk("access_addr", mem_addr, 32'(DST + 2 * blk + ph - 2));
                    chk("access_we", mem_we, 32'(ph >= 2));
                    if (ph == 2) chk("wdata_lo", mem_wdata, exp_word[7:0]);
                    if (ph == 3) chk("wdata_hi", mem_wdata, exp_word[15:8]);
                end
                acc_n++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            mem[SRC + 2 * i]     = src_cw[i][7:0];
            mem[SRC + 2 * i + 1] = src_cw[i][15:8];
            mem[DST + 2 * i]     = 8'($urandom);
            mem[DST + 2 * i + 1] = 8'($urandom);
        end
        acc_n    = 0;
        done_cnt = 0;
    endtask

    task automatic rand_src();
        for (int i = 0; i < N; i++) src_cw[i] = 16'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_sgl"}, sgl_cnt, 0);
        chk({tag, "_dbl"}, dbl_cnt, 0);
    endtask

    task automatic do_run(input bit rnd, input bit poke_start, output int cyc);
        int          ns = 0;
        int          nd = 0;
        logic [15:0] r;
        load_mem();
        gnt_rand = rnd;
        @(negedge Clk);
        Start = 1'b1;
        cyc = -1;
        while (cyc < 3000) begin
            @(posedge Clk);
            #1 Start = 1'b0;
            cyc++;
            @(negedge Clk);
            if (Done) break;
            if (poke_start && cyc == 20) Start = 1'b1;
        end
        chk("done_seen", Done, 1);
        repeat (3) @(negedge Clk);
        chk("done_pulses", done_cnt, 1);
        chk("access_total", acc_n, 4 * N);
        chk("busy_after_run", Busy, 0);
        for (int i = 0; i < N; i++) begin
            r = model(src_cw[i]);
            chk("result_lo", mem[DST + 2 * i], r[7:0]);
            chk("result_hi", mem[DST + 2 * i + 1], r[15:8]);
            if (r[15:14] == 2'b01) ns++;
            if (r[15:14] == 2'b10) nd++;
        end
`ifdef ECC_SCRUB_STATS_EN
        chk("sgl_cnt", sgl_cnt, (ns > 15) ? 15 : ns);
        chk("dbl_cnt", dbl_cnt, (nd > 15) ? 15 : nd);
`else
        chk("sgl_cnt_tied", sgl_cnt, 0);
        chk("dbl_cnt_tied", dbl_cnt, 0);
`endif
    endtask

    initial begin
        int cyc;
        int guard;
        Reset   = 1'b0;
        Start   = 1'b0;
        mem_gnt = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < N; i++) src_cw[i] = 16'h0000;
        #1;
        check_outputs_zero("reset");

        chk("model_ffff", model(16'hFFFF), 16'h07FF);
        chk("model_0008", model(16'h0008), 16'h4000);
        chk("model_fffe", model(16'hFFFE), 16'h47FF);
        chk("model_0028", model(16'h0028), 16'h8003);
        chk("model_0000", model(16'h0000), 16'h0000);

        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        chk("no_autostart_busy", Busy, 0);
        chk("no_autostart_req", mem_req, 0);

        // Directed codewords, grant held high for latency
        rand_src();
        src_cw[0] = 16'hFFFF;
        src_cw[1] = 16'h0008;
        src_cw[2] = 16'hFFFE;
        src_cw[3] = 16'h0028;
        do_run(1'b0, 1'b0, cyc);
        chk("done_cycle", cyc, 76);
        chk("blk0_lo", mem[DST + 0], 8'hFF);
        chk("blk0_hi", mem[DST + 1], 8'h07);
        chk("blk1_lo", mem[DST + 2], 8'h00);
        chk("blk1_hi", mem[DST + 3], 8'h40);
        chk("blk2_lo", mem[DST + 4], 8'hFF);
        chk("blk2_hi", mem[DST + 5], 8'h47);
        chk("blk3_lo", mem[DST + 6], 8'h03);
        chk("blk3_hi", mem[DST + 7], 8'h80);

        // Random codewords with stalling grant; one run pokes Start mid-run
        for (int k = 0; k < 3; k++) begin
            rand_src();
            do_run(1'b1, k == 1, cyc);
        end

        // Reset during block 7 WR_LO, then a clean rerun
        rand_src();
        load_mem();
        gnt_rand = 1'b1;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
        end while (!(mem_req && mem_we && mem_addr == 8'(DST + 14)) && guard < 2000);
        chk("reached_blk7_wr_lo", 32'(guard < 2000), 1);
        #2 Reset = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        chk("post_reset_idle", Busy, 0);
        chk("post_reset_no_req", mem_req, 0);
        rand_src();
        do_run(1'b1, 1'b0, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameter NUM_BLOCKS, default 15: number of 16-bit codewords processed per run.
REQ-002 Parameter SRC_BASE, default 30: byte address of block 0 low byte; block i low byte = SRC_BASE+2i, high byte = SRC_BASE+2i+1.
REQ-003 Parameter DST_BASE, default 0: byte address of result 0 low byte; result i low = DST_BASE+2i, high = DST_BASE+2i+1.
REQ-004 Clk  in  1  sole clock, all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  begin a run; sampled only in IDLE.
REQ-007 Busy  out  1  high in every state except IDLE and DONE.
REQ-008 Done  out  1  one-cycle completion pulse.
REQ-009 mem_req  out  1  request for the shared data-memory port.
REQ-010 mem_gnt  in  1  arbiter grant; access completes on an edge where mem_req && mem_gnt.
REQ-011 mem_addr  out  8  byte address.
REQ-012 mem_we  out  1  1 = write, 0 = read.
REQ-013 mem_wdata  out  8  write data.
REQ-014 mem_rdata  in  8  read data, valid the cycle after the completing read edge.
REQ-015 sgl_cnt, dbl_cnt  out  4 each  saturating single/double error counts (see Configuration).

Function
REQ-016 FSM states: IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE.
REQ-017 IDLE -> RD_LO when Start=1; block index cleared to 0; Start in any other state ignored.
REQ-018 RD_LO, RD_HI, WR_LO, WR_HI each assert mem_req and hold mem_addr/mem_we/mem_wdata stable until mem_gnt=1, then advance.
REQ-019 RD_HI captures low byte from mem_rdata; DECODE captures high byte, forms the codeword, computes the result; DECODE lasts exactly one cycle, mem_req=0.
REQ-020 Codeword bit map: [0]=p0, [1]=p1, [2]=p2, [3]=d1, [4]=p4, [7:5]=d4..d2, [8]=p8, [15:9]=d11..d5.
REQ-021 Syndrome s[3:0] = XOR of indices of all set bits in positions 1..15; overall parity q = XOR of all 16 bits.
REQ-022 s=0,q=0: no error, flags=2'b00, data unchanged.
REQ-023 q=1: single error (includes s=0, i.e. p0 flipped), bit s inverted before extraction, flags=2'b01.
REQ-024 s!=0,q=0: double error, no correction, flags=2'b10.
REQ-025 Result = {flags, 3'b000, d11..d1}; WR_LO writes result[7:0], WR_HI writes result[15:8].
REQ-026 After WR_HI: index < NUM_BLOCKS-1 -> increment, RD_LO; else -> DONE.
REQ-027 DONE asserts Done for one cycle, then -> IDLE.
REQ-028 With mem_gnt held 1, Start sampled at edge 0 gives Done high in the cycle after edge 5*NUM_BLOCKS+1 (76 for default).
REQ-029 mem_req never asserted in IDLE, DECODE, DONE.

Reset
REQ-030 Reset=0 forces IDLE immediately, including mid-run; Done, Busy, mem_req, mem_we = 0; mem_addr, mem_wdata = 0; index and counters = 0.
REQ-031 Reset release alone never starts a run; a new Start is required.

Configuration
REQ-032 Macro ECC_SCRUB_STATS_EN defined: sgl_cnt/dbl_cnt increment in DECODE on single/double classification, saturate at 15, clear on accepted Start.
REQ-033 Macro undefined: counter logic absent, sgl_cnt and dbl_cnt tied to 0; all other behaviour identical.

Verification
REQ-034 Codeword 16'hFFFF at block 0, gnt=1 -> mem[1]=8'h07, mem[0]=8'hFF; Done at cycle 76.
REQ-035 Codeword 16'h0008 (bit 3 flipped from zero) -> result 16'h4000; with stats, sgl_cnt=1.
REQ-036 Codeword 16'hFFFE (p0 flipped) -> result 16'h47FF.
REQ-037 Codeword 16'h0028 (bits 3,5 flipped) -> result 16'h8003; with stats, dbl_cnt=1.
REQ-038 mem_gnt toggled pseudo-randomly -> address/data stable while ungranted, all 15 results correct, Done once.
REQ-039 Reset=0 during block 7 WR_LO -> outputs zero same cycle, IDLE; later Start reruns all 15 blocks correctly.
